mem_word_master: RTL and testbench



---
 rtl/mem_word_master.sv | 177 +++++++++++++++++
 tb/tb_mem_word_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_word_master.sv
// Byte-serial RAM initiator: splits one NBYTES-wide load/store into consecutive
// byte transactions on the 8-bit RAM port and returns the assembled word or a store ack.
module mem_word_master #(
    parameter int unsigned NBYTES     = 4,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [7:0]            req_addr,
    input  logic [8*NBYTES-1:0]   req_wdata,
    output logic                  resp_valid,
    output logic [8*NBYTES-1:0]   resp_rdata,
    output logic                  memwrite,
    output logic [7:0]            adr,
    output logic [7:0]            writedata,
    input  logic [7:0]            memdata
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } state_t;

    state_t          state, state_n;
    logic            ready_n;
    logic            valid_n;
    logic [W-1:0]    rdata_n;
    logic            memwrite_n;
    logic [7:0]      adr_n;
    logic [7:0]      writedata_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [W-1:0]    asm_q, asm_n;
    logic            wr_q, wr_n;
    logic [7:0]      base_q, base_n;
    logic [W-1:0]    wdat_q, wdat_n;

    // Word lane holding transfer byte idx (byte 0 lives at the lowest address).
    function automatic logic [CW-1:0] lane_of(input logic [CW-1:0] idx);
        lane_of = BIG_ENDIAN ? (LAST - idx) : idx;
    endfunction

    function automatic logic [7:0] get_byte(input logic [W-1:0] word,
                                            input logic [CW-1:0] idx);
        logic [7:0]    b;
        logic [CW-1:0] ln;
        b  = 8'h00;
        ln = lane_of(idx);
        for (int unsigned j = 0; j < NBYTES; j++) begin
            if (ln == CW'(j)) begin
                b = word[8*j +: 8];
            end
        end
        return b;
    endfunction

    function automatic logic [W-1:0] set_byte(input logic [W-1:0] word,
                                              input logic [CW-1:0] idx,
                                              input logic [7:0]    b);
        logic [W-1:0]  r;
        logic [CW-1:0] ln;
        r  = word;
        ln = lane_of(idx);
        for (int unsigned j = 0; j < NBYTES; j++) begin
            if (ln == CW'(j)) begin
                r[8*j +: 8] = b;
            end
        end
        return r;
    endfunction

    // State and registered outputs; reset drops memwrite without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            memwrite   <= 1'b0;
            adr        <= 8'h00;
            writedata  <= 8'h00;
            cnt        <= '0;
            asm_q      <= '0;
            wr_q       <= 1'b0;
            base_q     <= 8'h00;
            wdat_q     <= '0;
        end else begin
            state      <= state_n;
            req_ready  <= ready_n;
            resp_valid <= valid_n;
            resp_rdata <= rdata_n;
            memwrite   <= memwrite_n;
            adr        <= adr_n;
            writedata  <= writedata_n;
            cnt        <= cnt_n;
            asm_q      <= asm_n;
            wr_q       <= wr_n;
            base_q     <= base_n;
            wdat_q     <= wdat_n;
        end
    end

    // Next-state and next-output logic; cnt indexes the byte on the bus this cycle.
    always_comb begin
        state_n     = state;
        ready_n     = req_ready;
        valid_n     = 1'b0;
        rdata_n     = resp_rdata;
        memwrite_n  = 1'b0;
        adr_n       = adr;
        writedata_n = writedata;
        cnt_n       = cnt;
        asm_n       = asm_q;
        wr_n        = wr_q;
        base_n      = base_q;
        wdat_n      = wdat_q;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_n    = XFER;
                    ready_n    = 1'b0;
                    wr_n       = req_write;
                    base_n     = req_addr;
                    wdat_n     = req_wdata;
                    cnt_n      = '0;
                    asm_n      = '0;
                    adr_n      = req_addr;
                    memwrite_n = req_write;
                    if (req_write) begin
                        writedata_n = get_byte(req_wdata, '0);
                    end
                end
            end

            XFER: begin
                // memdata now carries the byte addressed during the cycle just ending
                if (!wr_q) begin
                    asm_n = set_byte(asm_q, cnt, memdata);
                end
                if (cnt == LAST) begin
                    state_n = RESP;
                    valid_n = 1'b1;
                    if (!wr_q) begin
                        rdata_n = asm_n;
                    end
                end else begin
                    cnt_n      = cnt + 1'b1;
                    adr_n      = base_q + 8'(cnt_n);
                    memwrite_n = wr_q;
                    if (wr_q) begin
                        writedata_n = get_byte(wdat_q, cnt_n);
                    end
                end
            end

            RESP: begin
                state_n = IDLE;
                ready_n = 1'b1;
                cnt_n   = '0;
            end

            default: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_word_master.sv
// Bench for mem_word_master: little- and big-endian instances share one request
// stream; a transaction-level model predicts every output cycle by cycle.
module tb_mem_word_master;

    localparam int unsigned N    = 4;
    localparam int unsigned W    = 8 * N;
    localparam int          MAXC = 8192;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_write = 1'b0;
    logic [7:0]   req_addr = 8'h00;
    logic [W-1:0] req_wdata = '0;

    logic         rdy_le, vld_le, mw_le, rdy_be, vld_be, mw_be;
    logic [W-1:0] rd_le, rd_be;
    logic [7:0]   adr_le, wd_le, adr_be, wd_be;
    logic [7:0]   md_le = 8'h00;
    logic [7:0]   md_be = 8'h00;

    logic [7:0]   ram_le [256];
    logic [7:0]   ram_be [256];
    logic [7:0]   mod_le [256];
    logic [7:0]   mod_be [256];

    typedef struct {
        bit           v;
        bit           mw;
        bit           has_wd;
        bit           resp;
        bit           has_rd;
        logic [7:0]   adr;
        logic [7:0]   wdl;
        logic [7:0]   wdb;
        logic [W-1:0] rdl;
        logic [W-1:0] rdb;
    } ent_t;

    ent_t sched [MAXC];

    int cyc      = 0;
    int free_at  = 0;
    int checks   = 0;
    int failures = 0;

    logic [7:0]   h_adr = 8'h00, h_wdl = 8'h00, h_wdb = 8'h00;
    logic [W-1:0] h_rdl = '0, h_rdb = '0;

    mem_word_master #(.NBYTES(N), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(rdy_le), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(vld_le), .resp_rdata(rd_le),
        .memwrite(mw_le), .adr(adr_le), .writedata(wd_le), .memdata(md_le)
    );

    mem_word_master #(.NBYTES(N), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(rdy_be), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(vld_be), .resp_rdata(rd_be),
        .memwrite(mw_be), .adr(adr_be), .writedata(wd_be), .memdata(md_be)
    );

    always #5 clk = ~clk;

    // Byte-wide RAMs: write then registered read on every negedge.
    always @(negedge clk) begin
        if (mw_le === 1'b1) ram_le[adr_le] = wd_le;
        if (mw_be === 1'b1) ram_be[adr_be] = wd_be;
        md_le <= ram_le[adr_le];
        md_be <= ram_be[adr_be];
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Predict the whole timeline of a request accepted at posedge a.
    task automatic schedule(input int a, input bit w, input logic [7:0] base, input logic [W-1:0] d);
        ent_t e;
        logic [7:0] ai;
        if (a + int'(N) >= MAXC) return;
        for (int k = 0; k < int'(N); k++) begin
            e.v = 1'b1; e.mw = w; e.has_wd = w; e.resp = 1'b0; e.has_rd = 1'b0;
            e.adr = base + 8'(k);
            e.wdl = 8'(d >> (8 * k));
            e.wdb = 8'(d >> (8 * (int'(N) - 1 - k)));
            e.rdl = '0; e.rdb = '0;
            sched[a + k] = e;
        end
        e.v = 1'b1; e.mw = 1'b0; e.has_wd = 1'b0; e.resp = 1'b1; e.has_rd = !w;
        e.adr = base + 8'(N - 1);
        e.wdl = 8'h00; e.wdb = 8'h00; e.rdl = '0; e.rdb = '0;
        for (int i = 0; i < int'(N); i++) begin
            ai = base + 8'(i);
            e.rdl = e.rdl | (W'(mod_le[ai]) << (8 * i));
            e.rdb = e.rdb | (W'(mod_be[ai]) << (8 * (int'(N) - 1 - i)));
        end
        sched[a + int'(N)] = e;
        free_at = a + int'(N) + 2;
    endtask

    // Single compare point per cycle, mid-period.
    always @(negedge clk) begin
        logic exp_rdy, exp_mw, exp_vld;
        ent_t e;
        exp_rdy = 1'b1; exp_mw = 1'b0; exp_vld = 1'b0;
        if (reset) begin
            h_adr = 8'h00; h_wdl = 8'h00; h_wdb = 8'h00; h_rdl = '0; h_rdb = '0;
        end else if (cyc < MAXC && sched[cyc].v) begin
            e = sched[cyc];
            exp_rdy = 1'b0; exp_mw = e.mw; exp_vld = e.resp;
            h_adr = e.adr;
            if (e.has_wd) begin h_wdl = e.wdl; h_wdb = e.wdb; end
            if (e.has_rd) begin h_rdl = e.rdl; h_rdb = e.rdb; end
            if (e.mw) begin mod_le[e.adr] = e.wdl; mod_be[e.adr] = e.wdb; end
        end
        chk("req_ready_le", W'(rdy_le), W'(exp_rdy));
        chk("req_ready_be", W'(rdy_be), W'(exp_rdy));
        chk("resp_valid_le", W'(vld_le), W'(exp_vld));
        chk("resp_valid_be", W'(vld_be), W'(exp_vld));
        chk("memwrite_le", W'(mw_le), W'(exp_mw));
        chk("memwrite_be", W'(mw_be), W'(exp_mw));
        chk("adr_le", W'(adr_le), W'(h_adr));
        chk("adr_be", W'(adr_be), W'(h_adr));
        chk("writedata_le", W'(wd_le), W'(h_wdl));
        chk("writedata_be", W'(wd_be), W'(h_wdb));
        chk("resp_rdata_le", rd_le, h_rdl);
        chk("resp_rdata_be", rd_be, h_rdb);
    end

    task automatic step();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
    endtask

    task automatic set_mem(input logic [7:0] a, input logic [7:0] b);
        ram_le[a] = b; ram_be[a] = b; mod_le[a] = b; mod_be[a] = b;
    endtask

    // Present a request and hold it until the model says it is taken.
    task automatic issue(input bit w, input logic [7:0] a, input logic [W-1:0] d);
        bit acc;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            if (cyc + 1 >= free_at) begin
                schedule(cyc + 1, w, a, d);
                acc = 1'b1;
            end
            step();
        end
        if (!acc) chk("accept_timeout", W'(1), W'(0));
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int i = 0; i < 40 && cyc < free_at; i++) step();
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        logic [7:0]   b, s31, s32, s33;
        logic [W-1:0] d;
        bit           w;
        logic [7:0]   a;
        int           bad_le, bad_be;

        for (int i = 0; i < MAXC; i++) sched[i].v = 1'b0;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            set_mem(8'(i), b);
        end
        set_mem(8'h10, 8'h11); set_mem(8'h11, 8'h22);
        set_mem(8'h12, 8'h33); set_mem(8'h13, 8'h44);

        repeat (3) step();
        reset = 1'b0;
        free_at = cyc + 1;
        step();

        issue(1'b0, 8'h10, '0);
        drain();
        chk("s1_load_le", rd_le, 32'h44332211);
        chk("s1_load_be", rd_be, 32'h11223344);

        issue(1'b1, 8'h20, 32'hDEADBEEF);
        drain();
        chk("s2_ram_le_20", W'(ram_le[8'h20]), W'(8'hEF));
        chk("s2_ram_le_23", W'(ram_le[8'h23]), W'(8'hDE));
        chk("s2_ram_be_20", W'(ram_be[8'h20]), W'(8'hDE));
        issue(1'b0, 8'h20, '0);
        drain();
        chk("s2_load_le", rd_le, 32'hDEADBEEF);
        chk("s2_load_be", rd_be, 32'hDEADBEEF);

        issue(1'b1, 8'hFE, 32'hA1B2C3D4);
        drain();
        chk("s3_ram_fe", W'(ram_le[8'hFE]), W'(8'hD4));
        chk("s3_ram_ff", W'(ram_le[8'hFF]), W'(8'hC3));
        chk("s3_ram_00", W'(ram_le[8'h00]), W'(8'hB2));
        chk("s3_ram_01", W'(ram_le[8'h01]), W'(8'hA1));
        issue(1'b0, 8'hFE, '0);
        drain();
        chk("s3_load_le", rd_le, 32'hA1B2C3D4);
        chk("s3_load_be", rd_be, 32'hA1B2C3D4);

        // back-to-back with req_valid held high throughout
        d = $urandom;
        issue(1'b0, 8'h10, '0);
        issue(1'b1, 8'h40, d);
        issue(1'b0, 8'h40, '0);
        drain();
        chk("b2b_load_le", rd_le, d);
        chk("b2b_load_be", rd_be, d);

        // reset during cycle 2 of a store
        s31 = ram_le[8'h31]; s32 = ram_le[8'h32]; s33 = ram_le[8'h33];
        issue(1'b1, 8'h30, 32'h55667788);
        req_valid = 1'b0;
        step();
        #1;
        reset = 1'b1;
        for (int i = cyc; i < MAXC; i++) sched[i].v = 1'b0;
        #1;
        chk("rst_async_mw_le", W'(mw_le), W'(0));
        chk("rst_async_mw_be", W'(mw_be), W'(0));
        repeat (2) step();
        reset = 1'b0;
        free_at = cyc + 1;
        step();
        chk("rst_ready_after", W'(rdy_le), W'(1));
        chk("rst_ram_30", W'(ram_le[8'h30]), W'(8'h88));
        chk("rst_ram_31", W'(ram_le[8'h31]), W'(s31));
        chk("rst_ram_32", W'(ram_le[8'h32]), W'(s32));
        chk("rst_ram_33", W'(ram_le[8'h33]), W'(s33));
        chk("rst_ram_be_30", W'(ram_be[8'h30]), W'(8'h55));

        for (int t = 0; t < 150; t++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 255)) : 8'($urandom);
            d = $urandom;
            issue(w, a, d);
            idle($urandom_range(0, 3));
        end
        drain();
        step();

        bad_le = 0; bad_be = 0;
        for (int i = 0; i < 256; i++) begin
            if (ram_le[i] !== mod_le[i]) bad_le++;
            if (ram_be[i] !== mod_be[i]) bad_be++;
        end
        chk("final_ram_le", W'(bad_le), W'(0));
        chk("final_ram_be", W'(bad_be), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
